// File: rtl/ccff_loader_if.sv
// rtl/ccff_loader_if.sv - bitstream byte stream in and chain readback bytes out
interface ccff_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] rb_data;
    logic       rb_valid;

    modport master (output s_data, s_valid, input s_ready, rb_data, rb_valid);
    modport slave  (input s_data, s_valid, output s_ready, rb_data, rb_valid);
endinterface

// File: rtl/ccff_loader.sv
// rtl/ccff_loader.sv - serialises bitstream bytes into the ccff chain and packs tail bits into readback bytes
module ccff_loader #(
    parameter int CHAIN_LEN = 24,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic         prog_clk,
    input  logic         prog_reset,
    input  logic         start,
    ccff_loader_if.slave bus,
    output logic         ccff_head,
    output logic         ccff_shift_en,
    input  logic         ccff_tail,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

    state_t             state, state_nxt;
    logic [7:0]         byte_reg;
    logic [3:0]         cnt;
    logic [CNT_W-1:0]   remaining;
    logic [7:0]         rb_shift;
    logic [3:0]         rb_cnt;
    logic [7:0]         rb_data_q;
    logic               rb_valid_q;

    logic               in_load;
    logic               accept;
    logic               last_bit;
    logic               rb_flush;
    logic [7:0]         rb_next;
    logic [3:0]         rb_cnt_inc;

    assign in_load       = (state == ST_LOAD);
    assign ccff_head     = byte_reg[7];
    assign ccff_shift_en = in_load && (cnt != 4'd0) && (remaining != '0);

    // Refill one cycle early (cnt==1 while shifting) so byte boundaries have no bubble;
    // never take a byte that the remaining chain length cannot use.
    assign bus.s_ready = in_load
                       && ((cnt == 4'd0) || ((cnt == 4'd1) && ccff_shift_en))
                       && (32'(remaining) > 32'(cnt));
    assign accept      = bus.s_ready && bus.s_valid;
    assign last_bit    = ccff_shift_en && (remaining == CNT_W'(1));

    assign rb_next     = {rb_shift[6:0], ccff_tail};
    assign rb_cnt_inc  = rb_cnt + 4'd1;
    assign rb_flush    = ccff_shift_en && ((rb_cnt_inc == 4'd8) || last_bit);

    assign bus.rb_data  = rb_data_q;
    assign bus.rb_valid = rb_valid_q;
    assign busy         = in_load;
    assign done         = (state == ST_DONE);

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)    state_nxt = ST_LOAD;
            ST_LOAD: if (last_bit) state_nxt = ST_DONE;
            ST_DONE: if (start)    state_nxt = ST_LOAD;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            byte_reg   <= '0;
            cnt        <= '0;
            remaining  <= '0;
            rb_shift   <= '0;
            rb_cnt     <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_valid_q <= 1'b0;
            if (!in_load && start) begin
                remaining <= CNT_W'(CHAIN_LEN);
                cnt       <= '0;
                byte_reg  <= '0;
                rb_shift  <= '0;
                rb_cnt    <= '0;
            end else if (in_load) begin
                if (ccff_shift_en) begin
                    byte_reg  <= {byte_reg[6:0], 1'b0};
                    cnt       <= cnt - 4'd1;
                    remaining <= remaining - CNT_W'(1);
                    rb_shift  <= rb_next;
                    rb_cnt    <= rb_flush ? 4'd0 : rb_cnt_inc;
                    if (rb_flush) begin
                        rb_valid_q <= 1'b1;
                        // Short final byte is left-justified with zero fill.
                        rb_data_q  <= rb_next << (4'd8 - rb_cnt_inc);
                    end
                end
                if (accept) begin
                    byte_reg <= bus.s_data;
                    cnt      <= 4'd8;
                end
            end
        end
    end
endmodule

// File: tb/tb_ccff_loader.sv
// tb/tb_ccff_loader.sv - scoreboard bench for ccff_loader with behavioural chain models
module tb_ccff_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, start_a, start_b;
    logic head_a, head_b, sh_a, sh_b, busy_a, busy_b, done_a, done_b;
    logic tail_a, tail_b;

    ccff_loader_if ifa();
    ccff_loader_if ifb();

    ccff_loader #(.CHAIN_LEN(24)) dut_a (
        .prog_clk(clk), .prog_reset(rst_a), .start(start_a), .bus(ifa),
        .ccff_head(head_a), .ccff_shift_en(sh_a), .ccff_tail(tail_a),
        .busy(busy_a), .done(done_a));

    ccff_loader #(.CHAIN_LEN(20)) dut_b (
        .prog_clk(clk), .prog_reset(rst_b), .start(start_b), .bus(ifb),
        .ccff_head(head_b), .ccff_shift_en(sh_b), .ccff_tail(tail_b),
        .busy(busy_b), .done(done_b));

    // Chain models: plain shift registers clocked by the enable, with a preload port.
    logic [23:0] chain_a, pre_val_a;
    logic [19:0] chain_b, pre_val_b;
    logic        pre_a, pre_b;
    always @(posedge clk) begin
        if (pre_a)     chain_a <= pre_val_a;
        else if (sh_a) chain_a <= {chain_a[22:0], head_a};
        if (pre_b)     chain_b <= pre_val_b;
        else if (sh_b) chain_b <= {chain_b[18:0], head_b};
    end
    assign tail_a = chain_a[23];
    assign tail_b = chain_b[19];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit         exp_head_a[$], exp_head_b[$];
    logic [7:0] exp_rb_a[$], exp_rb_b[$];
    int shifts_a = 0, shifts_b = 0, idle_a = 0, idle_b = 0, acc_a = 0, acc_b = 0;
    int last_a = 0, last_b = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (sh_a === 1'b1) begin
            shifts_a++;
            last_a = cyc;
            chk("head_a_expected", exp_head_a.size() != 0, 1);
            if (exp_head_a.size() != 0) chk("head_a", head_a, exp_head_a.pop_front());
        end else if (busy_a === 1'b1) idle_a++;
        if (ifa.rb_valid === 1'b1) begin
            chk("rb_a_expected", exp_rb_a.size() != 0, 1);
            if (exp_rb_a.size() != 0) chk("rb_data_a", ifa.rb_data, exp_rb_a.pop_front());
        end
        if (ifa.s_valid === 1'b1 && ifa.s_ready === 1'b1) acc_a++;
    end

    always @(negedge clk) begin
        if (sh_b === 1'b1) begin
            shifts_b++;
            last_b = cyc;
            chk("head_b_expected", exp_head_b.size() != 0, 1);
            if (exp_head_b.size() != 0) chk("head_b", head_b, exp_head_b.pop_front());
        end else if (busy_b === 1'b1) idle_b++;
        if (ifb.rb_valid === 1'b1) begin
            chk("rb_b_expected", exp_rb_b.size() != 0, 1);
            if (exp_rb_b.size() != 0) chk("rb_data_b", ifb.rb_data, exp_rb_b.pop_front());
        end
        if (ifb.s_valid === 1'b1 && ifb.s_ready === 1'b1) acc_b++;
    end

    task automatic exp_byte(bit b, logic [7:0] d, int nb);
        for (int i = 7; i >= 8 - nb; i--) begin
            if (b) exp_head_b.push_back(d[i]);
            else   exp_head_a.push_back(d[i]);
        end
    endtask

    task automatic exp_rb(bit b, logic [7:0] d);
        if (b) exp_rb_b.push_back(d);
        else   exp_rb_a.push_back(d);
    endtask

    task automatic do_start(bit b);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic preload(bit b, logic [23:0] v);
        if (b) begin pre_val_b = v[19:0]; pre_b = 1'b1; end
        else   begin pre_val_a = v;       pre_a = 1'b1; end
        @(negedge clk);
        pre_a = 1'b0;
        pre_b = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken, s_valid still high.
    task automatic send(bit b, logic [7:0] d);
        int g = 0;
        if (b) begin ifb.s_data = d; ifb.s_valid = 1'b1; end
        else   begin ifa.s_data = d; ifa.s_valid = 1'b1; end
        while (((b ? ifb.s_ready : ifa.s_ready) !== 1'b1) && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("send_ready_timeout", g < 100, 1);
        @(negedge clk);
    endtask

    task automatic wait_done(bit b, int exp_shifts, int exp_idle, int bs, int bi);
        int g = 0;
        while (((b ? done_b : done_a) !== 1'b1) && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("done_timeout", g < 300, 1);
        chk("done_latency", cyc, (b ? last_b : last_a) + 1);
        chk("busy_at_done", b ? busy_b : busy_a, 0);
        chk("shift_count", (b ? shifts_b : shifts_a) - bs, exp_shifts);
        chk("stall_cycles", (b ? idle_b : idle_a) - bi, exp_idle);
        @(negedge clk);
        chk("head_queue_drained", b ? exp_head_b.size() : exp_head_a.size(), 0);
        chk("rb_queue_drained", b ? exp_rb_b.size() : exp_rb_a.size(), 0);
        chk("done_held", b ? done_b : done_a, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bs, bi, ba, g;
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        pre_a = 1'b0; pre_b = 1'b0; pre_val_a = '0; pre_val_b = '0;
        ifa.s_data = 8'h00; ifa.s_valid = 1'b1;
        ifb.s_data = 8'h00; ifb.s_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", ifa.s_ready, 0);
        chk("rst_shift_en", sh_a, 0);
        chk("rst_rb_valid", ifa.rb_valid, 0);
        chk("rst_rb_data", ifa.rb_data, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_head", head_a, 0);
        chk("rst_b_s_ready", ifb.s_ready, 0);
        chk("rst_b_done", done_b, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_s_ready", ifa.s_ready, 0);
        end
        chk("idle_no_accept", acc_a, 0);
        ifa.s_valid = 1'b0; ifb.s_valid = 1'b0;

        // Full-rate load over a chain preloaded with 0x123456
        preload(0, 24'h123456);
        bs = shifts_a; bi = idle_a;
        exp_byte(0, 8'hA5, 8); exp_byte(0, 8'h3C, 8); exp_byte(0, 8'hF0, 8);
        exp_rb(0, 8'h12); exp_rb(0, 8'h34); exp_rb(0, 8'h56);
        do_start(0);
        chk("start_busy", busy_a, 1);
        chk("start_s_ready", ifa.s_ready, 1);
        send(0, 8'hA5); send(0, 8'h3C); send(0, 8'hF0);
        ifa.s_valid = 1'b0;
        wait_done(0, 24, 1, bs, bi);
        chk("chain_after_full", chain_a, 24'hA53CF0);

        // Five-cycle underrun after the first byte
        bs = shifts_a; bi = idle_a;
        exp_byte(0, 8'hA5, 8); exp_byte(0, 8'h3C, 8); exp_byte(0, 8'hF0, 8);
        exp_rb(0, 8'hA5); exp_rb(0, 8'h3C); exp_rb(0, 8'hF0);
        do_start(0);
        send(0, 8'hA5);
        ifa.s_valid = 1'b0;
        g = 0;
        while (!(busy_a === 1'b1 && sh_a === 1'b0) && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("stall_seen", g < 50, 1);
        repeat (4) @(negedge clk);
        send(0, 8'h3C); send(0, 8'hF0);
        ifa.s_valid = 1'b0;
        wait_done(0, 24, 6, bs, bi);
        chk("chain_after_stall", chain_a, 24'hA53CF0);

        // Readback: preload 0x123456 then load zeros
        preload(0, 24'h123456);
        bs = shifts_a; bi = idle_a;
        for (int i = 0; i < 3; i++) exp_byte(0, 8'h00, 8);
        exp_rb(0, 8'h12); exp_rb(0, 8'h34); exp_rb(0, 8'h56);
        do_start(0);
        send(0, 8'h00); send(0, 8'h00); send(0, 8'h00);
        ifa.s_valid = 1'b0;
        wait_done(0, 24, 1, bs, bi);
        chk("chain_cleared", chain_a, 24'h000000);

        // Abort at the tenth shift
        bs = shifts_a;
        exp_byte(0, 8'h5A, 8); exp_byte(0, 8'hC3, 2);
        exp_rb(0, 8'h00);
        do_start(0);
        send(0, 8'h5A); send(0, 8'hC3);
        ifa.s_valid = 1'b0;
        g = 0;
        while ((shifts_a - bs) < 9 && g < 50) begin
            @(posedge clk);
            g++;
        end
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_rb_valid", ifa.rb_valid, 0);
        chk("abort_shift_en", sh_a, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_quiet_rb", ifa.rb_valid, 0);
        end
        chk("abort_shifts", shifts_a - bs, 10);
        chk("abort_head_queue", exp_head_a.size(), 0);
        chk("abort_rb_queue", exp_rb_a.size(), 0);

        // Restart after abort: chain holds the ten bits that made it in
        bs = shifts_a; bi = idle_a;
        exp_byte(0, 8'h11, 8); exp_byte(0, 8'h22, 8); exp_byte(0, 8'h33, 8);
        exp_rb(0, 8'h00); exp_rb(0, 8'h01); exp_rb(0, 8'h6B);
        do_start(0);
        send(0, 8'h11); send(0, 8'h22); send(0, 8'h33);
        ifa.s_valid = 1'b0;
        wait_done(0, 24, 1, bs, bi);
        chk("chain_after_restart", chain_a, 24'h112233);

        // 20-bit chain: partial final byte, no fourth byte taken
        preload(1, 24'h0ABCDE);
        bs = shifts_b; bi = idle_b; ba = acc_b;
        exp_byte(1, 8'hFF, 8); exp_byte(1, 8'hFF, 8); exp_byte(1, 8'hA7, 4);
        exp_rb(1, 8'hAB); exp_rb(1, 8'hCD); exp_rb(1, 8'hE0);
        do_start(1);
        send(1, 8'hFF); send(1, 8'hFF); send(1, 8'hA7);
        ifb.s_data = 8'h55;
        wait_done(1, 20, 1, bs, bi);
        repeat (5) @(negedge clk);
        chk("partial_accepts", acc_b - ba, 3);
        chk("partial_s_ready", ifb.s_ready, 0);
        ifb.s_valid = 1'b0;
        chk("chain_b_final", chain_b, 20'hFFFFA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
